// File: rtl/elevator_pkg.sv
// Shared elevator types: travel direction, on/off flag, hall call slot state and
// the hall call arbiter state.
package elevator_pkg;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  typedef enum logic {ON = 1'b0, OFF = 1'b1} onoff_t;

  // Prefixed so the labels do not collide with onoff_t::OFF in this scope.
  typedef enum logic [1:0] {
    CALL_OFF,
    CALL_PENDING,
    CALL_OFFERED,
    CALL_SENT
  } call_st_t;

  typedef enum logic {IDLE, SEND} arb_st_t;

endpackage

// File: rtl/hall_button_sync.sv
// Conditions one raw hall button into a single-cycle press pulse. With
// HALL_CALL_SYNC_EN defined a 2-flop synchronizer precedes the edge detector.
module hall_button_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic sample;
  logic prev;

`ifdef HALL_CALL_SYNC_EN
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sample <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= btn;
      sample <= meta;
      prev   <= sample;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sample <= btn;
      prev   <= sample;
    end
  end
`endif

  // Both terms are flop outputs, so the pulse is glitch-free.
  assign press = sample & ~prev;

endmodule

// File: rtl/hall_call_panel.sv
// Hall call panel: latches floor button presses, lights lamps and offers calls
// round-robin to the group controller. Option macro: HALL_CALL_SYNC_EN.
module hall_call_panel
  import elevator_pkg::*;
#(
  parameter int FLOORS  = 6,
  parameter int FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  btn_up,
  input  logic [FLOORS-1:0]  btn_down,
  input  logic [FLOOR_W-1:0] car_floor,
  input  logic               car_dir,
  input  logic               door_open,
  output logic               req_valid,
  output logic [FLOOR_W-1:0] req_floor,
  output logic               req_dir,
  input  logic               req_ready,
  output logic [FLOORS-1:0]  up_lamp,
  output logic [FLOORS-1:0]  down_lamp
);

  localparam int SLOTS = 2 * FLOORS;
  localparam int IDX_W = $clog2(SLOTS);

  logic [SLOTS-1:0] press;
  logic [SLOTS-1:0] press_ok;
  logic [SLOTS-1:0] svc_hit;
  call_st_t         slot [SLOTS];
  arb_st_t          state;
  arb_st_t          state_nxt;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] pick;
  logic             pick_found;
  logic             offer;
  logic             handshake;

  for (genvar f = 0; f < FLOORS; f++) begin : g_btn
    hall_button_sync u_up (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_up[f]),
      .press (press[2*f])
    );
    hall_button_sync u_down (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_down[f]),
      .press (press[2*f+1])
    );
  end

  // No up call from the top floor and no down call from the ground floor.
  always_comb begin
    press_ok                 = press;
    press_ok[2*(FLOORS-1)]   = 1'b0;
    press_ok[1]              = 1'b0;
  end

  always_comb begin
    svc_hit = '0;
    if (door_open && (int'(car_floor) < FLOORS)) begin
      for (int f = 0; f < FLOORS; f++) begin
        if (int'(car_floor) == f) begin
          if (f == 0 || f == FLOORS - 1) begin
            svc_hit[2*f]   = 1'b1;
            svc_hit[2*f+1] = 1'b1;
          end else begin
            svc_hit[2*f + int'(car_dir)] = 1'b1;
          end
        end
      end
    end
  end

  // Scan offsets high to low so the pending slot nearest rr wins.
  always_comb begin : p_pick
    int j;
    j          = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      j = int'(rr) + k;
      if (j >= SLOTS) j = j - SLOTS;
      if (slot[j] == CALL_PENDING) begin
        pick       = IDX_W'(j);
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    offer     = 1'b0;
    handshake = 1'b0;
    req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          offer     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        req_valid = 1'b1;
        if (req_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_floor <= '0;
      req_dir   <= 1'b0;
      grant     <= '0;
      rr        <= '0;
    end else begin
      if (offer) begin
        grant     <= pick;
        req_floor <= FLOOR_W'(pick >> 1);
        req_dir   <= pick[0];
      end
      if (handshake) begin
        rr <= (grant == IDX_W'(SLOTS - 1)) ? '0 : grant + IDX_W'(1);
      end
    end
  end

  // Service outranks every other event on a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) slot[i] <= CALL_OFF;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (svc_hit[i]) begin
          slot[i] <= CALL_OFF;
        end else if (offer && pick == IDX_W'(i)) begin
          slot[i] <= CALL_OFFERED;
        end else if (handshake && grant == IDX_W'(i) && slot[i] == CALL_OFFERED) begin
          slot[i] <= CALL_SENT;
        end else if (press_ok[i] && slot[i] == CALL_OFF) begin
          slot[i] <= CALL_PENDING;
        end
      end
    end
  end

  always_comb begin
    for (int f = 0; f < FLOORS; f++) begin
      up_lamp[f]   = (slot[2*f]   != CALL_OFF);
      down_lamp[f] = (slot[2*f+1] != CALL_OFF);
    end
  end

endmodule

// File: tb/tb_hall_call_panel.sv
// Self-checking bench for hall_call_panel (default build): scoreboard of expected
// requests checked at each handshake, plus direct lamp and handshake checks.
module tb_hall_call_panel;

  logic       clk;
  logic       rst_n;
  logic [5:0] btn_up;
  logic [5:0] btn_down;
  logic [2:0] car_floor;
  logic       car_dir;
  logic       door_open;
  logic       req_valid;
  logic [2:0] req_floor;
  logic       req_dir;
  logic       req_ready;
  logic [5:0] up_lamp;
  logic [5:0] down_lamp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hs_count = 0;
  int last_hs  = 0;
  int prev_hs  = 0;
  int hs_before;
  logic [3:0] exp_q [$];
  logic [3:0] held;

  hall_call_panel #(.FLOORS(6), .FLOOR_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .car_floor (car_floor),
    .car_dir   (car_dir),
    .door_open (door_open),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_dir   (req_dir),
    .req_ready (req_ready),
    .up_lamp   (up_lamp),
    .down_lamp (down_lamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Handshake monitor: every accepted request must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("req_unexpected", 32'(req_valid), 32'd0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        checkOutput("req_payload", 32'({req_floor, req_dir}), 32'(e));
      end
      prev_hs = last_hs;
      last_hs = cyc;
      hs_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] up, input logic [5:0] down);
    btn_up   = up;
    btn_down = down;
    tick(1);
    btn_up   = '0;
    btn_down = '0;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    btn_up    = '0;
    btn_down  = '0;
    door_open = 1'b0;
    car_floor = '0;
    car_dir   = 1'b0;
    req_ready = 1'b0;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick(1);
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic waitValid(input string tag, input int budget);
    for (int n = 0; n < budget && !req_valid; n++) tick(1);
    checkOutput(tag, 32'(req_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n     = 1'b0;
    btn_up    = '0;
    btn_down  = '0;
    door_open = 1'b0;
    car_floor = '0;
    car_dir   = 1'b0;
    req_ready = 1'b0;
    tick(1);
    checkOutput("rst_valid", 32'(req_valid), 32'd0);
    checkOutput("rst_floor", 32'(req_floor), 32'd0);
    checkOutput("rst_dir", 32'(req_dir), 32'd0);
    checkOutput("rst_lamps", 32'({up_lamp, down_lamp}), 32'd0);

    // Single up call at floor 2; lamp stays lit once the call is sent.
    doReset();
    req_ready = 1'b1;
    exp_q.push_back({3'd2, 1'b0});
    applyStimulus(6'b000100, 6'b000000);
    waitDrain("t1_drain", 20);
    tick(2);
    checkOutput("t1_up_lamp", 32'(up_lamp), 32'h04);
    checkOutput("t1_down_lamp", 32'(down_lamp), 32'h00);

    // Two presses together: round-robin from slot 0, one idle cycle between offers.
    doReset();
    req_ready = 1'b1;
    exp_q.push_back({3'd1, 1'b0});
    exp_q.push_back({3'd5, 1'b1});
    applyStimulus(6'b000010, 6'b100000);
    waitDrain("t2_drain", 20);
    checkOutput("t2_gap", 32'(last_hs - prev_hs), 32'd2);

    // Back-pressure: payload holds while a later call waits as PENDING.
    doReset();
    exp_q.push_back({3'd3, 1'b1});
    applyStimulus(6'b000000, 6'b001000);
    waitValid("t3_valid", 20);
    held = {req_floor, req_dir};
    checkOutput("t3_payload", 32'(held), 32'h7);
    exp_q.push_back({3'd4, 1'b0});
    applyStimulus(6'b010000, 6'b000000);
    for (int n = 0; n < 9; n++) begin
      checkOutput("t3_hold_valid", 32'(req_valid), 32'd1);
      checkOutput("t3_hold_payload", 32'({req_floor, req_dir}), 32'(held));
      tick(1);
    end
    checkOutput("t3_up_lamp", 32'(up_lamp), 32'h10);
    checkOutput("t3_down_lamp", 32'(down_lamp), 32'h08);
    req_ready = 1'b1;
    waitDrain("t3_drain", 20);

    // Service coinciding with the press pulse drops the press.
    doReset();
    req_ready = 1'b1;
    hs_before = hs_count;
    car_floor = 3'd3;
    car_dir   = 1'b1;
    door_open = 1'b1;
    applyStimulus(6'b000000, 6'b001000);
    tick(2);
    door_open = 1'b0;
    tick(6);
    checkOutput("t4_down_lamp", 32'(down_lamp), 32'h00);
    checkOutput("t4_no_req", 32'(hs_count - hs_before), 32'd0);

    // End-floor service, out-of-range car floor, permanently ignored buttons.
    doReset();
    req_ready = 1'b1;
    exp_q.push_back({3'd0, 1'b0});
    applyStimulus(6'b000001, 6'b000000);
    waitDrain("t5_drain0", 20);
    checkOutput("t5_lamp0_on", 32'(up_lamp), 32'h01);
    exp_q.push_back({3'd1, 1'b0});
    applyStimulus(6'b000010, 6'b000000);
    waitDrain("t5_drain1", 20);
    car_floor = 3'd7;
    car_dir   = 1'b0;
    door_open = 1'b1;
    tick(1);
    door_open = 1'b0;
    tick(1);
    checkOutput("t5_floor7_noop", 32'(up_lamp), 32'h03);
    car_floor = 3'd0;
    car_dir   = 1'b1;
    door_open = 1'b1;
    tick(1);
    door_open = 1'b0;
    tick(1);
    checkOutput("t5_floor0_clear", 32'(up_lamp), 32'h02);
    hs_before = hs_count;
    applyStimulus(6'b100000, 6'b000001);
    tick(5);
    checkOutput("t5_ignored_up", 32'(up_lamp), 32'h02);
    checkOutput("t5_ignored_down", 32'(down_lamp), 32'h00);
    checkOutput("t5_no_req", 32'(hs_count - hs_before), 32'd0);

    // Reset during an offer drops the call with no clock edge needed.
    doReset();
    applyStimulus(6'b001000, 6'b000000);
    waitValid("t6_valid", 20);
    rst_n = 1'b0;
    #2;
    checkOutput("t6_async_valid", 32'(req_valid), 32'd0);
    checkOutput("t6_async_lamps", 32'({up_lamp, down_lamp}), 32'd0);
    exp_q.delete();
    req_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    hs_before = hs_count;
    tick(10);
    checkOutput("t6_no_req", 32'(hs_count - hs_before), 32'd0);
    checkOutput("t6_idle", 32'(req_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hall_call_panel.md
# hall_call_panel

Floor-side transmitter for hall calls. Samples the raw up/down push-buttons at every floor, latches each press as a call, and lights the button's lamp. Offers latched calls one at a time to the group controller over a valid/ready handshake. Extinguishes a call when a car opens its door at that floor travelling in the call's direction. Sits between the physical hall stations and `main_control`, replacing the direct per-cycle `random_up`/`random_down` request inputs.

## Interface
- `FLOORS`, 6: number of floors, numbered 0..FLOORS-1
- `FLOOR_W`, 3: bits per floor number; must satisfy 2^FLOOR_W >= FLOORS
- `clk` input 1: sole clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `btn_up` input FLOORS: raw up buttons, asynchronous level
- `btn_down` input FLOORS: raw down buttons, asynchronous level
- `car_floor` input FLOOR_W: floor of the car currently stopped
- `car_dir` input 1: committed direction of that car, UP=0, DOWN=1
- `door_open` input 1: car door is OPEN at `car_floor`
- `req_valid` output 1: a call is being offered
- `req_floor` output FLOOR_W: floor of the offered call
- `req_dir` output 1: direction of the offered call
- `req_ready` input 1: controller accepts the offered call
- `up_lamp` output FLOORS: up-call lamps
- `down_lamp` output FLOORS: down-call lamps

## Operation
- There are 2*FLOORS call slots, indexed `floor*2 + dir`. Each slot is in one of four states: OFF, PENDING, OFFERED, SENT.
- Press: a rising edge of the conditioned button takes an OFF slot to PENDING. A press on a slot that is not OFF is ignored.
  - `btn_up[FLOORS-1]` is ignored permanently.
  - `btn_down[0]` is ignored permanently.
- Lamp: `up_lamp`/`down_lamp` are high for every state except OFF.
- Arbiter FSM has two states, IDLE and SEND.
  - IDLE: if any slot is PENDING, pick the first one found scanning round-robin from pointer `rr`. Set that slot to OFFERED, load `req_floor`/`req_dir`, and go to SEND.
  - SEND: `req_valid`=1 and the payload is held stable until `req_ready`. On handshake the slot goes OFFERED->SENT, `rr` is set to the granted index +1 (wrapping from 2*FLOORS-1 to 0), and the FSM returns to IDLE.
- Service: when `door_open`=1, the slot (`car_floor`, `car_dir`) goes to OFF from any state.
  - At floor 0 and at floor FLOORS-1, both slots of that floor are cleared.
- Service of an OFFERED slot clears it to OFF. `req_valid` is still held until `req_ready`; the stale call is harmless to the controller. On that handshake the slot stays OFF.
- Simultaneous events on one slot:
  - Service and press in the same cycle: service wins, the slot ends OFF and the press is dropped.
  - Service and handshake in the same cycle: the slot ends OFF.
- `car_floor` >= FLOORS services nothing.
- Reset values, all applied asynchronously when `rst_n` goes low:
  - all slots OFF; lamps 0
  - `req_valid`=0; `req_floor`=0; `req_dir`=0
  - `rr`=0; FSM IDLE; synchronizer and edge registers 0
- Reset asserted mid-handshake drops the call silently.

## Timing
- Button sampled high at edge E (HALL_CALL_SYNC_EN defined): slot becomes PENDING and lamp rises after edge E+2. `req_valid` rises after edge E+3 at the earliest.
- Without the macro: PENDING after E+1, `req_valid` after E+2.
- Handshake at edge H: `req_valid` is 0 for the cycle after H; the next offer is valid after H+1. Requests are therefore at most one per two cycles.
- Service seen at edge S: lamp falls after S.
- Offered payload never changes while `req_valid`=1.

## Configuration
- `HALL_CALL_SYNC_EN` defined: each raw button passes through a 2-flop synchronizer, then a registered previous-value edge detector.
- Not defined: the raw button feeds the edge detector directly. This is for already-synchronous stimulus such as formal models. Latency is one cycle shorter.

## Structure
- Package `elevator_pkg` holds:
  - `dir` {UP, DOWN} and `onoff` {ON, OFF}, shared with car and controller
  - new `call_st` {OFF, PENDING, OFFERED, SENT}
  - arbiter state enum {IDLE, SEND}
- Sub-module `hall_button_sync`: one button, `clk`/`rst_n`, raw input in, one-cycle press pulse out. Contains the synchronizer under the macro. Instantiated 2*FLOORS times.

## Test plan
- Press `btn_up[2]` for one cycle, `req_ready`=1 → `up_lamp[2]` high; one request with floor 2, dir UP; slot SENT; lamp stays high.
- Press `btn_down[5]` and `btn_up[1]` in the same cycle with `rr`=0 → offers are floor 1 UP, then floor 5 DOWN, separated by one idle cycle.
- Hold `req_ready`=0 for 10 cycles while offering floor 3 DOWN → `req_valid` and payload are stable throughout; a press on floor 4 meanwhile stays PENDING.
- `door_open`=1, `car_floor`=3, `car_dir`=DOWN in the same cycle as a `btn_down[3]` edge → `down_lamp[3]` ends 0 and no request is issued.
- `door_open`=1 at `car_floor`=0 with up call 0 SENT → `up_lamp[0]` clears; a press of `btn_down[0]` produces no lamp.
- Pull `rst_n` low while `req_valid`=1 → `req_valid` and all lamps are 0 immediately; after release there are no requests until a new press.
